cdc_handshake_tx: RTL

//  Sending side of a 4-phase req/ack handshake. Moves a WIDTH-bit word from the clk domain to a

---
 rtl/cdc_handshake_tx.sv | 110 +++++++++++
 1 files changed

// File: rtl/cdc_handshake_tx.sv
// Sending side of a 4-phase req/ack handshake into a foreign clock domain.
// A local valid/ready word is held on data_out while req_out is high. The
// asynchronous ack_in comes back through a SYNC_STAGES-flop synchronizer.
module cdc_handshake_tx #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             req_out,
   output logic [WIDTH-1:0] data_out,
   input  logic             ack_in,
   output logic             done,
   output logic             proto_err
);

   typedef enum logic [1:0] {
      DRAIN   = 2'd0,
      IDLE    = 2'd1,
      REQ     = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic               ack_s;
   logic               req_d;
   logic               done_d;
   logic               err_d;
   logic               ready_d;
   logic [WIDTH-1:0]   data_d;

   assign ack_s = sync_q[SYNC_STAGES-1];

   // ack_in synchronizer; resets to all ones so nothing starts before a real ack low is seen
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], ack_in};
      end
   end

   // Next state and next registered outputs
   always_comb begin
      state_d = state_q;
      req_d   = req_out;
      data_d  = data_out;
      done_d  = 1'b0;
      err_d   = proto_err;
      unique case (state_q)
         DRAIN: begin
            req_d = 1'b0;
            if (!ack_s) state_d = IDLE;
         end
         IDLE: begin
            if (ack_s) begin
               // Remote is acking with no request outstanding: flag and wait for it to drop
               err_d   = 1'b1;
               state_d = DRAIN;
            end else if (in_valid) begin
               data_d  = in_data;
               req_d   = 1'b1;
               state_d = REQ;
            end
         end
         REQ: begin
            if (ack_s) begin
               req_d   = 1'b0;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            if (!ack_s) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            req_d   = 1'b0;
            state_d = DRAIN;
         end
      endcase
      ready_d = (state_d == IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= DRAIN;
         req_out   <= 1'b0;
         data_out  <= '0;
         done      <= 1'b0;
         proto_err <= 1'b0;
         in_ready  <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_out   <= req_d;
         data_out  <= data_d;
         done      <= done_d;
         proto_err <= err_d;
         in_ready  <= ready_d;
      end
   end

endmodule
